// File: rtl/fs_serial_sub.sv
// fs_serial_sub: bit-serial full subtractor.
// It computes D = A - B - Bin over WIDTH bits, LSB first, one bit per clock.
// A single full-subtractor cell and a borrow flop do the arithmetic.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request pulse, accepted in IDLE or DONE
//   A, B   minuend / subtrahend, sampled on the accepting edge
//   Bin    borrow-in, sampled on the accepting edge
//   D      registered difference, held until the next completion
//   Bo     registered borrow-out, held with D
//   busy   operation in progress
//   done   one-cycle completion strobe
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; D/Bo hold the last result
// RUN   | one bit processed per edge, LSB first
// DONE  | D/Bo just updated; start here chains the next operation

module fs_serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sa_nx;
    logic [WIDTH-1:0] sb, sb_nx;
    logic [WIDTH-1:0] r, r_nx;
    logic             br, br_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] d_nx;
    logic             bo_nx;

    // Full-subtractor cell on the current LSBs.
    logic cell_d;
    logic cell_br;
    assign cell_d  = sa[0] ^ sb[0] ^ br;
    assign cell_br = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);

    always_comb begin
        state_nx = state;
        sa_nx    = sa;
        sb_nx    = sb;
        r_nx     = r;
        br_nx    = br;
        cnt_nx   = cnt;
        d_nx     = D;
        bo_nx    = Bo;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    sa_nx    = A;
                    sb_nx    = B;
                    br_nx    = Bin;
                    cnt_nx   = '0;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                sa_nx  = sa >> 1;
                sb_nx  = sb >> 1;
                r_nx   = {cell_d, r[WIDTH-1:1]};
                br_nx  = cell_br;
                cnt_nx = cnt + CW'(1);
                // The last bit lands in R on the same edge it is published.
                // Taking the shifted value here means D never shows a partial result.
                if (cnt == LAST) begin
                    d_nx     = {cell_d, r[WIDTH-1:1]};
                    bo_nx    = cell_br;
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            r     <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            D     <= '0;
            Bo    <= 1'b0;
        end else begin
            state <= state_nx;
            sa    <= sa_nx;
            sb    <= sb_nx;
            r     <= r_nx;
            br    <= br_nx;
            cnt   <= cnt_nx;
            D     <= d_nx;
            Bo    <= bo_nx;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_fs_serial_sub.sv
module tb_fs_serial_sub;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Bin = 1'b0;
    logic [WIDTH-1:0] D;
    logic             Bo;
    logic             busy;
    logic             done;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       bin8 = 1'b0;
    logic [7:0] d8;
    logic       bo8;
    logic       busy8;
    logic       done8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fs_serial_sub #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
        .D(D), .Bo(Bo), .busy(busy), .done(done)
    );

    fs_serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Bin(bin8),
        .D(d8), .Bo(bo8), .busy(busy8), .done(done8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Reference model: counts cycles from the accepting edge and computes the
    // result with integer arithmetic.
    bit               m_run = 0;
    int               m_left = 0;
    int               m_res = 0;
    bit               m_bo = 0;
    logic             e_busy = 0;
    logic             e_done = 0;
    logic [WIDTH-1:0] e_d = '0;
    logic             e_bo = 0;
    bit               chk_en = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run = 0; m_left = 0;
            e_busy = 0; e_done = 0; e_d = '0; e_bo = 0;
        end else if (!m_run && start) begin
            m_run  = 1;
            m_left = WIDTH;
            m_res  = int'(A) - int'(B) - int'(Bin);
            m_bo   = int'(A) < (int'(B) + int'(Bin));
            e_busy = 1; e_done = 0;
        end else if (m_run) begin
            m_left--;
            if (m_left == 0) begin
                m_run  = 0;
                e_busy = 0; e_done = 1;
                e_d    = m_res[WIDTH-1:0];
                e_bo   = m_bo;
            end
        end else begin
            e_done = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy", busy, e_busy);
            chk("m_done", done, e_done);
            chk("m_d", D, e_d);
            chk("m_bo", Bo, e_bo);
            chk("m_excl", busy & done, 0);
        end
    end

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                          input logic [3:0] xd, input logic xbo, input string nm);
        int n;
        @(negedge clk);
        A = a; B = b; Bin = bi; start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!done && n < 30);
        chk({nm, "_lat"}, n - 1, WIDTH);
        chk({nm, "_d"}, D, xd);
        chk({nm, "_bo"}, Bo, xbo);
    endtask

    initial begin
        int n;
        int ndone;
        logic [4:0] full;

        // Reset held for two edges.
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_d", D, 0); chk("rst_bo", Bo, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk_en = 1;
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_d", D, 0); chk("idle_busy", busy, 0); chk("idle_done", done, 0);
        end

        // Directed basic vectors.
        run_op(4'd5,  4'd3,  1'b0, 4'd2,  1'b0, "b0");
        run_op(4'd3,  4'd5,  1'b0, 4'd14, 1'b1, "b1");
        run_op(4'd0,  4'd0,  1'b1, 4'd15, 1'b1, "b2");
        run_op(4'd15, 4'd15, 1'b0, 4'd0,  1'b0, "b3");

        // All 512 combinations, issued back-to-back from DONE.
        @(negedge clk);
        {A, B, Bin} = 9'd0;
        start = 1'b1;
        for (int i = 0; i < 512; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 30);
            chk("x_spacing", n, WIDTH + 1);
            full = {1'b0, A} - {1'b0, B} - {4'd0, Bin};
            chk("x_d", D, full[3:0]);
            chk("x_bo", Bo, full[4]);
            if (i < 511) {A, B, Bin} = 9'(i + 1);
            else start = 1'b0;
        end
        repeat (3) @(negedge clk);

        // start during RUN must not disturb the operation in flight.
        @(negedge clk);
        A = 4'd9; B = 4'd4; Bin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); A = 4'd1; B = 4'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("ign_d", D, 5);
                chk("ign_bo", Bo, 0);
            end
        end
        chk("ign_ndone", ndone, 1);

        // Reset in the middle of an operation.
        @(negedge clk);
        A = 4'd8; B = 4'd1; Bin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("mrst_d", D, 0); chk("mrst_bo", Bo, 0);
        chk("mrst_busy", busy, 0); chk("mrst_done", done, 0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mrst_ndone", ndone, 0);
        run_op(4'd6, 4'd6, 1'b1, 4'd15, 1'b1, "post");

        // Eight-bit instance.
        @(negedge clk);
        a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start8 = 1'b0;
            n++;
        end while (!done8 && n < 40);
        chk("w8_lat", n - 1, 8);
        chk("w8_d", d8, 8'hFF);
        chk("w8_bo", bo8, 1);
        chk("w8_excl", busy8 & done8, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
